// File: rtl/seg7_serial_rx.sv
// seg7_serial_rx: oversampling receiver and deserializer for the serial 7-segment display link.
// Define SEG7_RX_HEXDEC_EN to build the segment-to-hex decoder; without it hex and digit_ok read 0.
module seg7_serial_rx #(
  parameter int DIGITS      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seg_clk,
  input  logic                  seg_sout,
  input  logic                  seg_pen,
  input  logic                  seg_clrn,
  output logic [8*DIGITS-1:0]   frame,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [4*DIGITS-1:0]   hex,
  output logic [DIGITS-1:0]     digit_ok,
  output logic [6:0]            bit_cnt
);

  localparam int         FRAME_BITS = 8 * DIGITS;
  localparam logic [6:0] FRAME_CNT  = 7'(FRAME_BITS);
  localparam logic [3:0] LINK_RST   = 4'b1000;
  localparam int         I_SCLK     = 0;
  localparam int         I_SOUT     = 1;
  localparam int         I_PEN      = 2;
  localparam int         I_CLRN     = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FULL,
    S_OVER
  } state_t;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  hist_q, hist_d;
  logic                        sclk_rise_q, sclk_rise_d;
  logic                        pen_rise_q, pen_rise_d;
  logic                        clr_active;
  logic                        sout_s;

  state_t                      state_q, state_d;
  logic [FRAME_BITS-1:0]       shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]       frame_q, frame_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        frame_err_q, frame_err_d;
  logic [6:0]                  bit_cnt_q, bit_cnt_d;

  // Synchronizer -> history -> registered edge events. Rises are registered and clear is
  // taken from the history flop so every event lands SYNC_STAGES+1 cycles after sampling.
  always_comb begin
    sync_d[0] = {seg_clrn, seg_pen, seg_sout, seg_clk};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d      = sync_q[SYNC_STAGES-1];
    sclk_rise_d = sync_q[SYNC_STAGES-1][I_SCLK] & ~hist_q[I_SCLK];
    pen_rise_d  = sync_q[SYNC_STAGES-1][I_PEN]  & ~hist_q[I_PEN];
  end

  assign clr_active = ~hist_q[I_CLRN];
  assign sout_s     = hist_q[I_SOUT];

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = frame_err_q;
    if (clr_active) begin
      shreg_d   = '0;
      bit_cnt_d = '0;
      state_d   = S_IDLE;
    end else if (pen_rise_q) begin
      // A shift arriving in the same cycle as the latch is dropped.
      if (state_q == S_FULL) begin
        frame_d       = shreg_q;
        frame_valid_d = 1'b1;
      end else begin
        frame_err_d = 1'b1;
      end
      bit_cnt_d = '0;
      state_d   = S_IDLE;
    end else if (sclk_rise_q) begin
      shreg_d   = {shreg_q[FRAME_BITS-2:0], sout_s};
      bit_cnt_d = (bit_cnt_q == 7'h7F) ? bit_cnt_q : bit_cnt_q + 7'd1;
      case (state_q)
        S_IDLE, S_SHIFT: state_d = (bit_cnt_q + 7'd1 == FRAME_CNT) ? S_FULL : S_SHIFT;
        default:         state_d = S_OVER;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= {SYNC_STAGES{LINK_RST}};
      hist_q        <= LINK_RST;
      sclk_rise_q   <= 1'b0;
      pen_rise_q    <= 1'b0;
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      frame_q       <= '1;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      hist_q        <= hist_d;
      sclk_rise_q   <= sclk_rise_d;
      pen_rise_q    <= pen_rise_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  // Partial frames are invalidated by bit_cnt, so the shift register itself needs no reset.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign bit_cnt     = bit_cnt_q;

`ifdef SEG7_RX_HEXDEC_EN
  logic [4*DIGITS-1:0] hex_q, hex_d;
  logic [DIGITS-1:0]   digit_ok_q, digit_ok_d;

  // Returns {match, nibble}; the dp bit never reaches this table.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h03:   r = 5'h1B;
      7'h46:   r = 5'h1C;
      7'h21:   r = 5'h1D;
      7'h06:   r = 5'h1E;
      7'h0E:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    logic [4:0] dec;
    dec        = '0;
    hex_d      = '0;
    digit_ok_d = '0;
    for (int d = 0; d < DIGITS; d++) begin
      dec              = seg_decode(frame_d[8*d +: 7]);
      hex_d[4*d +: 4]  = dec[3:0];
      digit_ok_d[d]    = dec[4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q      <= '0;
      digit_ok_q <= '0;
    end else begin
      hex_q      <= hex_d;
      digit_ok_q <= digit_ok_d;
    end
  end

  assign hex      = hex_q;
  assign digit_ok = digit_ok_q;
`else
  assign hex      = '0;
  assign digit_ok = '0;
`endif

endmodule

// File: tb/tb_seg7_serial_rx.sv
// Testbench for seg7_serial_rx: directed vector table, multi-cycle corner sequences and
// randomized frames checked against a queue-based model of the link.
module tb_seg7_serial_rx;

`ifdef SEG7_RX_HEXDEC_EN
  localparam bit HEXDEC = 1'b1;
`else
  localparam bit HEXDEC = 1'b0;
`endif

  localparam logic [7:0] GLYPH [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_clk = 1'b0;
  logic        seg_sout = 1'b0;
  logic        seg_pen = 1'b0;
  logic        seg_clrn = 1'b1;
  logic [63:0] frame;
  logic        frame_valid;
  logic        frame_err;
  logic [31:0] hex;
  logic [7:0]  digit_ok;
  logic [6:0]  bit_cnt;

  seg7_serial_rx dut (
    .clk         (clk),
    .rst         (rst),
    .seg_clk     (seg_clk),
    .seg_sout    (seg_sout),
    .seg_pen     (seg_pen),
    .seg_clrn    (seg_clrn),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .hex         (hex),
    .digit_ok    (digit_ok),
    .bit_cnt     (bit_cnt)
  );

  always #5 clk = ~clk;

  int vld_cnt = 0;
  always @(posedge clk) begin
    if (frame_valid === 1'b1) vld_cnt <= vld_cnt + 1;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Link model: the bits received since the last clear/latch, and latched results.
  bit          mq[$];
  int          mcnt;
  logic [63:0] mframe;
  logic        merr;

  task automatic m_reset();
    mq.delete();
    mcnt   = 0;
    mframe = '1;
    merr   = 1'b0;
  endtask

  task automatic m_shift(input bit b);
    mq.push_back(b);
    if (mq.size() > 64) void'(mq.pop_front());
    if (mcnt < 127) mcnt++;
  endtask

  task automatic m_latch();
    logic [63:0] f;
    f = '0;
    if (mcnt == 64) begin
      foreach (mq[i]) f = {f[62:0], mq[i]};
      mframe = f;
    end else begin
      merr = 1'b1;
    end
    mcnt = 0;
  endtask

  function automatic void m_decode(input logic [63:0] f, output logic [31:0] h, output logic [7:0] ok);
    h  = '0;
    ok = '0;
    if (HEXDEC) begin
      for (int d = 0; d < 8; d++) begin
        for (int k = 0; k < 16; k++) begin
          if ((f[8*d +: 8] | 8'h80) == GLYPH[k]) begin
            h[4*d +: 4] = 4'(k);
            ok[d]       = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    seg_sout = b;
    wait_clks(2);
    seg_clk = 1'b1;
    wait_clks(4);
    seg_clk = 1'b0;
    wait_clks(2);
    m_shift(b);
  endtask

  task automatic send_bits(input logic [127:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic pulse_pen();
    seg_pen = 1'b1;
    wait_clks(4);
    seg_pen = 1'b0;
    wait_clks(6);
    m_latch();
  endtask

  typedef struct {
    int           nbits;
    logic [127:0] bits;
    logic [63:0]  exp_frame;
    logic         exp_err;
    int           exp_vld;
    logic [31:0]  exp_hex;
    logic [7:0]   exp_ok;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int          v0;
    logic [31:0] eh;
    logic [7:0]  eo;
    logic [127:0] rb;
    logic [7:0]  g;
    int          nb;

    vecs[0] = '{64, {64'h0, 64'hF9A4B0999282F880}, 64'hF9A4B0999282F880, 1'b0, 1, 32'h12345678, 8'hFF};
    vecs[1] = '{63, {64'h0, 64'h0123456789ABCDEF}, 64'hF9A4B0999282F880, 1'b1, 0, 32'h12345678, 8'hFF};
    vecs[2] = '{66, {64'h3, 64'h0123456789ABCDEF}, 64'hF9A4B0999282F880, 1'b1, 0, 32'h12345678, 8'hFF};
    vecs[3] = '{64, {64'h0, 64'hC0C0C0C0C0C0C0C0}, 64'hC0C0C0C0C0C0C0C0, 1'b1, 1, 32'h00000000, 8'hFF};
    vecs[4] = '{64, {64'h0, 64'h4079FF3019120278}, 64'h4079FF3019120278, 1'b1, 1, 32'h01034567, 8'hDF};

    m_reset();
    wait_clks(4);
    chk("rst_frame", {63'h0, 1'b0} | frame, 64'hFFFFFFFFFFFFFFFF);
    chk("rst_valid", 64'(frame_valid), 64'h0);
    chk("rst_err", 64'(frame_err), 64'h0);
    chk("rst_hex", 64'(hex), 64'h0);
    chk("rst_ok", 64'(digit_ok), 64'h0);
    chk("rst_cnt", 64'(bit_cnt), 64'h0);
    rst = 1'b0;
    wait_clks(6);

    for (int i = 0; i < 5; i++) begin
      v0 = vld_cnt;
      send_bits(vecs[i].bits, vecs[i].nbits);
      pulse_pen();
      chk($sformatf("vec%0d_frame", i), frame, vecs[i].exp_frame);
      chk($sformatf("vec%0d_err", i), 64'(frame_err), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_valid", i), 64'(vld_cnt - v0), 64'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_hex", i), 64'(hex), HEXDEC ? 64'(vecs[i].exp_hex) : 64'h0);
      chk($sformatf("vec%0d_ok", i), 64'(digit_ok), HEXDEC ? 64'(vecs[i].exp_ok) : 64'h0);
      chk($sformatf("vec%0d_cnt", i), 64'(bit_cnt), 64'h0);
    end

    // Clear in the middle of a frame, then a clean frame.
    send_bits(128'h2AAA_AAAA, 30);
    chk("clr_cnt_pre", 64'(bit_cnt), 64'd30);
    seg_clrn = 1'b0;
    wait_clks(5);
    chk("clr_cnt_during", 64'(bit_cnt), 64'h0);
    seg_clrn = 1'b1;
    wait_clks(5);
    mq.delete();
    mcnt = 0;
    v0 = vld_cnt;
    send_bits({64'h0, 64'h8E86A1C683889080}, 64);
    pulse_pen();
    chk("clr_frame", frame, 64'h8E86A1C683889080);
    chk("clr_valid", 64'(vld_cnt - v0), 64'd1);
    chk("clr_hex", 64'(hex), HEXDEC ? 64'hFEDCBA98 : 64'h0);
    chk("clr_err_sticky", 64'(frame_err), 64'd1);

    // Reset with a partial frame in flight.
    send_bits({64'h0, 64'hFF_1234_5678}, 40);
    rst = 1'b1;
    wait_clks(2);
    chk("mrst_frame", frame, 64'hFFFFFFFFFFFFFFFF);
    chk("mrst_err", 64'(frame_err), 64'h0);
    chk("mrst_hex", 64'(hex), 64'h0);
    chk("mrst_ok", 64'(digit_ok), 64'h0);
    chk("mrst_cnt", 64'(bit_cnt), 64'h0);
    rst = 1'b0;
    m_reset();
    wait_clks(6);
    v0 = vld_cnt;
    send_bits({64'h0, 64'hF9A4B0999282F880}, 64);
    pulse_pen();
    chk("mrst_valid", 64'(vld_cnt - v0), 64'd1);
    chk("mrst_frame2", frame, 64'hF9A4B0999282F880);
    chk("mrst_err2", 64'(frame_err), 64'h0);

    // Counter saturation on an overlong burst.
    nb = 130;
    for (int i = 0; i < nb; i++) send_bit(1'($urandom));
    chk("sat_cnt", 64'(bit_cnt), 64'd127);
    v0 = vld_cnt;
    pulse_pen();
    chk("sat_err", 64'(frame_err), 64'd1);
    chk("sat_valid", 64'(vld_cnt - v0), 64'd0);

    // Randomized frames against the model.
    for (int it = 0; it < 12; it++) begin
      rb = '0;
      for (int d = 0; d < 16; d++) begin
        g = GLYPH[$urandom_range(0, 15)];
        if ($urandom_range(0, 1) == 1) g[7] = 1'b0;
        if ($urandom_range(0, 3) == 0) g = 8'($urandom);
        rb[8*d +: 8] = g;
      end
      nb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(60, 68)) : 64;
      v0 = vld_cnt;
      send_bits(rb, nb);
      chk($sformatf("rnd%0d_cnt_pre", it), 64'(bit_cnt), 64'(mcnt));
      pulse_pen();
      m_decode(mframe, eh, eo);
      chk($sformatf("rnd%0d_frame", it), frame, mframe);
      chk($sformatf("rnd%0d_err", it), 64'(frame_err), 64'(merr));
      chk($sformatf("rnd%0d_valid", it), 64'(vld_cnt - v0), (nb == 64) ? 64'd1 : 64'd0);
      chk($sformatf("rnd%0d_hex", it), 64'(hex), 64'(eh));
      chk($sformatf("rnd%0d_ok", it), 64'(digit_ok), 64'(eo));
      chk($sformatf("rnd%0d_cnt", it), 64'(bit_cnt), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
